// File: rtl/ysyx_25060170_exu_seq.sv
// Execute stage with valid/ready handshakes on both sides.
// ALU ops, branch compares and jump targets finish in one cycle.
// When YSYX_25060170_EXU_MDU_EN is defined, MUL/DIV/REM run on an iterative
// shift-add / restoring-divide datapath for XLEN cycles. Without the macro,
// those ops finish in one cycle with result 0.
module ysyx_25060170_exu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [3:0]      i_alu_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [2:0]      i_br_op,
    input  logic [1:0]      i_jmp_op,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_kill,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_br_taken,
    output logic [XLEN-1:0] o_jump_addr,
    output logic            o_busy
);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_PASS = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_REM  = 4'd10, OP_SRA  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12, OP_REMU = 4'd13, OP_SLT  = 4'd14, OP_SLTU = 4'd15;

`ifdef YSYX_25060170_EXU_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_br_taken;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_jump_addr;

    logic [SHW-1:0]         w_sh;
    logic signed [XLEN-1:0] w_sop1, w_sop2, w_srs1, w_srs2;
    logic [XLEN-1:0]        w_alu;
    logic                   w_br;
    logic [XLEN-1:0]        w_jsum;
    logic [XLEN-1:0]        w_jaddr;

    assign w_sh   = i_op2[SHW-1:0];
    assign w_sop1 = i_op1;
    assign w_sop2 = i_op2;
    assign w_srs1 = i_rs1_val;
    assign w_srs2 = i_rs2_val;
    assign w_jsum = i_imm + i_op1;

    // Single-cycle ALU; MDU opcodes fall to the default and yield 0
    always_comb begin
        w_alu = '0;
        case (i_alu_op)
            OP_ADD:  w_alu = i_op1 + i_op2;
            OP_SUB:  w_alu = i_op1 - i_op2;
            OP_AND:  w_alu = i_op1 & i_op2;
            OP_OR:   w_alu = i_op1 | i_op2;
            OP_XOR:  w_alu = i_op1 ^ i_op2;
            OP_PASS: w_alu = i_op1;
            OP_SLL:  w_alu = i_op1 << w_sh;
            OP_SRL:  w_alu = i_op1 >> w_sh;
            OP_SRA:  w_alu = w_sop1 >>> w_sh;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_sop1 < w_sop2};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, i_op1 < i_op2};
            default: w_alu = '0;
        endcase
    end

    // Branch condition on rs1/rs2; codes 0 and 7 never take
    always_comb begin
        w_br = 1'b0;
        case (i_br_op)
            3'd1:    w_br = (i_rs1_val == i_rs2_val);
            3'd2:    w_br = (i_rs1_val != i_rs2_val);
            3'd3:    w_br = (w_srs1 < w_srs2);
            3'd4:    w_br = !(w_srs1 < w_srs2);
            3'd5:    w_br = (i_rs1_val < i_rs2_val);
            3'd6:    w_br = !(i_rs1_val < i_rs2_val);
            default: w_br = 1'b0;
        endcase
    end

    // Jump target; JALR clears bit 0, no-jump codes give 0
    always_comb begin
        w_jaddr = '0;
        case (i_jmp_op)
            2'd1:    w_jaddr = w_jsum;
            2'd2:    w_jaddr = {w_jsum[XLEN-1:1], 1'b0};
            default: w_jaddr = '0;
        endcase
    end

`ifdef YSYX_25060170_EXU_MDU_EN
    logic            w_is_mdu;
    logic            w_sgn;
    logic [XLEN-1:0] w_abs1, w_abs2;
    logic [3:0]      r_mop;
    logic [XLEN-1:0] r_a;      // multiplier / dividend-then-quotient
    logic [XLEN-1:0] r_b;      // multiplicand / divisor magnitude
    logic [XLEN-1:0] r_acc;    // product accumulator / partial remainder
    logic [XLEN-1:0] r_op1;    // original dividend for REM by zero
    logic            r_neg_q, r_neg_r, r_div0;
    logic [SHW-1:0]  r_cnt;
    logic [XLEN:0]   w_rem_sh, w_diff;
    logic [XLEN-1:0] w_nxt_a, w_nxt_b, w_nxt_acc, w_mdu_res;

    assign w_is_mdu = (i_alu_op == OP_MUL) || (i_alu_op == OP_DIV) || (i_alu_op == OP_REM) ||
                      (i_alu_op == OP_DIVU) || (i_alu_op == OP_REMU);
    assign w_sgn    = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    assign w_abs1   = (w_sgn && i_op1[XLEN-1]) ? -i_op1 : i_op1;
    assign w_abs2   = (w_sgn && i_op2[XLEN-1]) ? -i_op2 : i_op2;

    // One shift-add or restoring-divide step per BUSY cycle
    always_comb begin
        w_rem_sh  = {r_acc, r_a[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_b};
        w_nxt_a   = r_a;
        w_nxt_b   = r_b;
        w_nxt_acc = r_acc;
        if (r_mop == OP_MUL) begin
            w_nxt_acc = r_acc + (r_a[0] ? r_b : '0);
            w_nxt_a   = r_a >> 1;
            w_nxt_b   = r_b << 1;
        end else if (!w_diff[XLEN]) begin
            w_nxt_acc = w_diff[XLEN-1:0];
            w_nxt_a   = {r_a[XLEN-2:0], 1'b1};
        end else begin
            w_nxt_acc = w_rem_sh[XLEN-1:0];
            w_nxt_a   = {r_a[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and divide-by-zero overrides on the final step.
    // Most-negative / -1 needs no special case: the magnitude quotient is
    // already the most-negative pattern and the remainder is 0.
    always_comb begin
        w_mdu_res = '0;
        case (r_mop)
            OP_MUL:          w_mdu_res = w_nxt_acc;
            OP_DIV, OP_DIVU: w_mdu_res = r_div0 ? '1 : (r_neg_q ? -w_nxt_a : w_nxt_a);
            default:         w_mdu_res = r_div0 ? r_op1 : (r_neg_r ? -w_nxt_acc : w_nxt_acc);
        endcase
    end
`endif

    // Control FSM with registered handshake/status outputs and datapath regs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_br_taken  <= 1'b0;
            r_result    <= '0;
            r_jump_addr <= '0;
`ifdef YSYX_25060170_EXU_MDU_EN
            r_cnt   <= '0;
            r_mop   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_op1   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
`endif
        end else if (i_kill) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_in_ready  <= 1'b0;
                        r_br_taken  <= w_br;
                        r_jump_addr <= w_jaddr;
`ifdef YSYX_25060170_EXU_MDU_EN
                        if (w_is_mdu) begin
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                            r_cnt   <= SHW'(XLEN-1);
                            r_mop   <= i_alu_op;
                            r_op1   <= i_op1;
                            r_acc   <= '0;
                            r_a     <= (i_alu_op == OP_MUL) ? i_op2 : w_abs1;
                            r_b     <= (i_alu_op == OP_MUL) ? i_op1 : w_abs2;
                            r_neg_q <= w_sgn && (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
                            r_neg_r <= w_sgn && i_op1[XLEN-1];
                            r_div0  <= (i_op2 == '0);
                        end else begin
`endif
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu;
`ifdef YSYX_25060170_EXU_MDU_EN
                        end
`endif
                    end
                end
`ifdef YSYX_25060170_EXU_MDU_EN
                S_BUSY: begin
                    r_a   <= w_nxt_a;
                    r_b   <= w_nxt_b;
                    r_acc <= w_nxt_acc;
                    if (r_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mdu_res;
                    end else begin
                        r_cnt <= r_cnt - SHW'(1);
                    end
                end
`endif
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_result    = r_result;
    assign o_br_taken  = r_br_taken;
    assign o_jump_addr = r_jump_addr;

endmodule
